// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. One full-adder cell and a carry
//               flop process the operands LSB first, one bit per clock,
//               behind a start/busy/done handshake. S/Cout (and ovf) are
//               updated only when an operation completes and are otherwise
//               held.
//               Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf
//               output (signed two's-complement overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_cw = $clog2(WIDTH + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    // Counter value while the MSB is being processed
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [c_cw-1:0]  r_cnt;

    logic             w_sum;
    logic             w_cnext;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    // Single full-adder cell working on the current LSBs and the carry flop
    assign w_sum      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cnext    = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    // A new request is taken in IDLE and also in DONE (back-to-back operation)
    assign w_accept = start && ((r_state == c_idle) || (r_state == c_done));

    // Handshake FSM, serial datapath and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_c     <= Cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        r_state <= c_run;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                c_run: begin
                    // start is ignored here; captured operands keep shifting
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_c   <= w_cnext;
                    r_cnt <= r_cnt + c_cw'(1);
                    if (r_cnt == c_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        S       <= w_res_next;
                        Cout    <= w_cnext;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_c is the carry into the MSB, w_cnext the carry out
                        ovf     <= r_c ^ w_cnext;
`endif
                        r_state <= c_done;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition counterpart of the ripple subtractor datapath in this lab.
- Processes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake. Results stay held until the next accepted operation.
- Intended as the sequential, area-minimal adder for the lab's ALU comparison against the combinational ripple designs.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only when not busy
- A  input  WIDTH  augend, captured on accepted start
- B  input  WIDTH  addend, captured on accepted start
- Cin  input  1  carry in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse when S/Cout become valid
- S  output  WIDTH  sum, held stable between operations
- Cout  output  1  final carry out, held stable between operations

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge; overrides everything):
  - state=IDLE; busy=0, done=0, S=0, Cout=0.
  - Internal shift registers, carry flip-flop and bit counter cleared.
  - Applies identically mid-operation: the partial result is discarded and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge -> capture A, B and Cin (Cin into the carry flop); counter=0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN (busy=1, done=0), at each edge:
  - sum bit = a[0] ^ b[0] ^ c.
  - c <= (a[0]&b[0]) | (c&(a[0]^b[0])).
  - Shift a and b right by 1; shift the sum bit into the MSB of the result register (so the result is right-aligned after WIDTH shifts).
  - counter += 1.
  - On the edge processing bit WIDTH-1: go to DONE; S <= full result; Cout <= final carry.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0. Then go to IDLE.
  - start=1 during DONE is accepted exactly as in IDLE (back-to-back operation). Next state is RUN and the new operands are captured.
- Latency: start sampled at edge k -> done=1 during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- S/Cout:
  - Updated only on the final RUN edge.
  - Never show partial sums.
  - Keep their value through IDLE and through the next RUN until that operation completes.
- Ignored inputs:
  - start while in RUN is ignored; operands are not re-captured and the operation continues.
  - A/B/Cin changes after capture have no effect.
- Arithmetic: unsigned modulo 2^WIDTH, with Cout as bit WIDTH of A+B+Cin.
- Counter width: $clog2(WIDTH+1) bits; it never wraps within one operation.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit): signed two's-complement overflow, equal to (carry into the MSB) XOR (carry out of the MSB).
  - ovf is registered together with S/Cout and has the same hold and reset behaviour (reset value 0).
- Undefined:
  - No ovf port and no extra logic.
  - All other behaviour is identical.

Test Plan (WIDTH=4):
- A=7, B=9, Cin=0, start pulse -> busy high for 4 cycles; done pulse 5 cycles after the start edge; S=0, Cout=1.
- A=15, B=15, Cin=1 -> S=15, Cout=1. Then A=0, B=0, Cin=0 -> S=0, Cout=0. Check S stays 15 during the second run until its done.
- Start A=3, B=4; re-pulse start with A=8, B=8 on the 2nd RUN cycle -> result S=7, Cout=0; done after the original 5 cycles; second request ignored.
- Start A=5, B=6; assert rst on the 2nd RUN cycle -> next cycle busy=0, done=0, S=0, Cout=0; no done pulse follows.
- Back-to-back: start held high -> ops A=1,B=2 then A=9,B=9 -> done pulses every 5 cycles; S=3/Cout=0, then S=2/Cout=1.
- SERIAL_ADDER_OVF_EN defined:
  - A=7, B=1 -> S=8, ovf=1.
  - A=8, B=8 -> S=0, Cout=1, ovf=1.
  - A=15, B=1 -> S=0, Cout=1, ovf=0.
